// File: rtl/hack_kbd_decoder.sv
// PS/2 set-2 event word to Nand2Tetris Hack KBD register value.
// Tracks shift/caps-lock and the single held key; KBD returns to 0 when that key is released.
module hack_kbd_decoder (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [10:0] ps2_key,
    output logic [15:0] kbd,
    output logic        kbd_strobe,
    output logic        caps
);

    // Letter position within a..z, or invalid.
    function automatic logic [5:0] letter_index(input logic [7:0] sc);
        logic [5:0] r;
        r = 6'd0;
        case (sc)
            8'h1C: r = {1'b1, 5'd0};
            8'h32: r = {1'b1, 5'd1};
            8'h21: r = {1'b1, 5'd2};
            8'h23: r = {1'b1, 5'd3};
            8'h24: r = {1'b1, 5'd4};
            8'h2B: r = {1'b1, 5'd5};
            8'h34: r = {1'b1, 5'd6};
            8'h33: r = {1'b1, 5'd7};
            8'h43: r = {1'b1, 5'd8};
            8'h3B: r = {1'b1, 5'd9};
            8'h42: r = {1'b1, 5'd10};
            8'h4B: r = {1'b1, 5'd11};
            8'h3A: r = {1'b1, 5'd12};
            8'h31: r = {1'b1, 5'd13};
            8'h44: r = {1'b1, 5'd14};
            8'h4D: r = {1'b1, 5'd15};
            8'h15: r = {1'b1, 5'd16};
            8'h2D: r = {1'b1, 5'd17};
            8'h1B: r = {1'b1, 5'd18};
            8'h2C: r = {1'b1, 5'd19};
            8'h3C: r = {1'b1, 5'd20};
            8'h2A: r = {1'b1, 5'd21};
            8'h1D: r = {1'b1, 5'd22};
            8'h22: r = {1'b1, 5'd23};
            8'h35: r = {1'b1, 5'd24};
            8'h1A: r = {1'b1, 5'd25};
            default: r = 6'd0;
        endcase
        return r;
    endfunction

    // Digit/punctuation keys: {valid, unshifted ASCII, shifted ASCII}; caps never applies.
    function automatic logic [16:0] glyph(input logic [7:0] sc);
        logic [16:0] r;
        r = 17'd0;
        case (sc)
            8'h16: r = {1'b1, 8'd49, 8'd33};   // 1 !
            8'h1E: r = {1'b1, 8'd50, 8'd64};   // 2 @
            8'h26: r = {1'b1, 8'd51, 8'd35};   // 3 #
            8'h25: r = {1'b1, 8'd52, 8'd36};   // 4 $
            8'h2E: r = {1'b1, 8'd53, 8'd37};   // 5 %
            8'h36: r = {1'b1, 8'd54, 8'd94};   // 6 ^
            8'h3D: r = {1'b1, 8'd55, 8'd38};   // 7 &
            8'h3E: r = {1'b1, 8'd56, 8'd42};   // 8 *
            8'h46: r = {1'b1, 8'd57, 8'd40};   // 9 (
            8'h45: r = {1'b1, 8'd48, 8'd41};   // 0 )
            8'h0E: r = {1'b1, 8'd96, 8'd126};  // ` ~
            8'h4E: r = {1'b1, 8'd45, 8'd95};   // - _
            8'h55: r = {1'b1, 8'd61, 8'd43};   // = +
            8'h54: r = {1'b1, 8'd91, 8'd123};  // [ {
            8'h5B: r = {1'b1, 8'd93, 8'd125};  // ] }
            8'h5D: r = {1'b1, 8'd92, 8'd124};  // backslash |
            8'h4C: r = {1'b1, 8'd59, 8'd58};   // ; :
            8'h52: r = {1'b1, 8'd39, 8'd34};   // ' "
            8'h41: r = {1'b1, 8'd44, 8'd60};   // , <
            8'h49: r = {1'b1, 8'd46, 8'd62};   // . >
            8'h4A: r = {1'b1, 8'd47, 8'd63};   // / ?
            default: r = 17'd0;
        endcase
        return r;
    endfunction

    // Hack control codes (128+) and space: {valid, code}.
    function automatic logic [8:0] special(input logic ext, input logic [7:0] sc);
        logic [8:0] r;
        r = 9'd0;
        if (sc == 8'h5A) begin
            r = {1'b1, 8'd128};
        end else if (ext) begin
            case (sc)
                8'h6B: r = {1'b1, 8'd130};
                8'h75: r = {1'b1, 8'd131};
                8'h74: r = {1'b1, 8'd132};
                8'h72: r = {1'b1, 8'd133};
                8'h6C: r = {1'b1, 8'd134};
                8'h69: r = {1'b1, 8'd135};
                8'h7D: r = {1'b1, 8'd136};
                8'h7A: r = {1'b1, 8'd137};
                8'h70: r = {1'b1, 8'd138};
                8'h71: r = {1'b1, 8'd139};
                default: r = 9'd0;
            endcase
        end else begin
            case (sc)
                8'h29: r = {1'b1, 8'd32};
                8'h66: r = {1'b1, 8'd129};
                8'h76: r = {1'b1, 8'd140};
                8'h05: r = {1'b1, 8'd141};
                8'h06: r = {1'b1, 8'd142};
                8'h04: r = {1'b1, 8'd143};
                8'h0C: r = {1'b1, 8'd144};
                8'h03: r = {1'b1, 8'd145};
                8'h0B: r = {1'b1, 8'd146};
                8'h83: r = {1'b1, 8'd147};
                8'h0A: r = {1'b1, 8'd148};
                8'h01: r = {1'b1, 8'd149};
                8'h09: r = {1'b1, 8'd150};
                8'h78: r = {1'b1, 8'd151};
                8'h07: r = {1'b1, 8'd152};
                default: r = 9'd0;
            endcase
        end
        return r;
    endfunction

    logic        tog_reg;
    logic        armed_reg;
    logic [7:0]  kbd_reg,      kbd_next;
    logic [8:0]  held_reg,     held_next;
    logic        held_vld_reg, held_vld_next;
    logic        lshift_reg,   lshift_next;
    logic        rshift_reg,   rshift_next;
    logic        caps_reg,     caps_next;
    logic        strobe_reg,   strobe_next;

    logic        ev;
    logic        make;
    logic [8:0]  key;
    logic        shift;
    logic [5:0]  let_r;
    logic [16:0] gly_r;
    logic [8:0]  spc_r;
    logic        map_vld;
    logic [7:0]  map_code;

    assign ev    = armed_reg && (ps2_key[10] != tog_reg);
    assign make  = ps2_key[9];
    assign key   = ps2_key[8:0];
    assign shift = lshift_reg | rshift_reg;

    assign let_r = letter_index(ps2_key[7:0]);
    assign gly_r = glyph(ps2_key[7:0]);
    assign spc_r = special(ps2_key[8], ps2_key[7:0]);

    // Printable keys only exist non-extended; specials decode both forms themselves.
    always_comb begin
        map_vld  = 1'b0;
        map_code = 8'd0;
        if (!ps2_key[8] && let_r[5]) begin
            map_vld  = 1'b1;
            map_code = ((shift ^ caps_reg) ? 8'd65 : 8'd97) + {3'd0, let_r[4:0]};
        end else if (!ps2_key[8] && gly_r[16]) begin
            map_vld  = 1'b1;
            map_code = shift ? gly_r[7:0] : gly_r[15:8];
        end else if (spc_r[8]) begin
            map_vld  = 1'b1;
            map_code = spc_r[7:0];
        end
    end

    always_comb begin
        kbd_next      = kbd_reg;
        held_next     = held_reg;
        held_vld_next = held_vld_reg;
        lshift_next   = lshift_reg;
        rshift_next   = rshift_reg;
        caps_next     = caps_reg;
        if (ev) begin
            if (key == 9'h012) begin
                lshift_next = make;
            end else if (key == 9'h059) begin
                rshift_next = make;
            end else if (key == 9'h058) begin
                if (make) caps_next = ~caps_reg;
            end else if (make) begin
                if (map_vld) begin
                    kbd_next      = map_code;
                    held_next     = key;
                    held_vld_next = 1'b1;
                end
            end else if (held_vld_reg && (held_reg == key)) begin
                kbd_next      = 8'd0;
                held_next     = 9'd0;
                held_vld_next = 1'b0;
            end
        end
        strobe_next = (kbd_next != kbd_reg);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tog_reg      <= 1'b0;
            armed_reg    <= 1'b0;
            kbd_reg      <= 8'd0;
            held_reg     <= 9'd0;
            held_vld_reg <= 1'b0;
            lshift_reg   <= 1'b0;
            rshift_reg   <= 1'b0;
            caps_reg     <= 1'b0;
            strobe_reg   <= 1'b0;
        end else begin
            tog_reg      <= ps2_key[10];
            armed_reg    <= 1'b1;
            kbd_reg      <= kbd_next;
            held_reg     <= held_next;
            held_vld_reg <= held_vld_next;
            lshift_reg   <= lshift_next;
            rshift_reg   <= rshift_next;
            caps_reg     <= caps_next;
            strobe_reg   <= strobe_next;
        end
    end

    assign kbd        = {8'h00, kbd_reg};
    assign kbd_strobe = strobe_reg;
    assign caps       = caps_reg;

endmodule

// File: tb/tb_hack_kbd_decoder.sv
// Bench for hack_kbd_decoder: directed test-plan steps plus random key traffic
// checked against a table-driven keyboard model.
module tb_hack_kbd_decoder;

    logic        clk;
    logic        reset_n;
    logic [10:0] ps2_key;
    logic [15:0] kbd;
    logic        kbd_strobe;
    logic        caps;

    hack_kbd_decoder dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .ps2_key    (ps2_key),
        .kbd        (kbd),
        .kbd_strobe (kbd_strobe),
        .caps       (caps)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests_run = 0;
    int tests_failed = 0;

    // Model tables indexed by {ext, scancode}; -1 means unmapped.
    int base_tbl[512];
    int shf_tbl[512];
    bit ltr_tbl[512];
    int pool[$];

    // Model state.
    int m_kbd, m_held;
    bit m_lsh, m_rsh, m_caps, m_strobe;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic build_tables();
        string letters;
        int lsc[26] = '{'h1C,'h32,'h21,'h23,'h24,'h2B,'h34,'h33,'h43,'h3B,'h42,'h4B,'h3A,
                        'h31,'h44,'h4D,'h15,'h2D,'h1B,'h2C,'h3C,'h2A,'h1D,'h22,'h35,'h1A};
        int gsc[21] = '{'h16,'h1E,'h26,'h25,'h2E,'h36,'h3D,'h3E,'h46,'h45,
                        'h0E,'h4E,'h55,'h54,'h5B,'h5D,'h4C,'h52,'h41,'h49,'h4A};
        int lo_tbl[21] = '{49,50,51,52,53,54,55,56,57,48,96,45,61,91,93,92,59,39,44,46,47};
        int hi_tbl[21] = '{33,64,35,36,37,94,38,42,40,41,126,95,43,123,125,124,58,34,60,62,63};
        int spk[27] = '{'h029,'h05A,'h15A,'h066,'h16B,'h175,'h174,'h172,'h16C,'h169,'h17D,'h17A,
                        'h170,'h171,'h076,'h005,'h006,'h004,'h00C,'h003,'h00B,'h083,'h00A,'h001,
                        'h009,'h078,'h007};
        int spc[27] = '{32,128,128,129,130,131,132,133,134,135,136,137,138,139,140,
                        141,142,143,144,145,146,147,148,149,150,151,152};
        letters = "abcdefghijklmnopqrstuvwxyz";
        for (int i = 0; i < 512; i++) begin
            base_tbl[i] = -1; shf_tbl[i] = -1; ltr_tbl[i] = 1'b0;
        end
        for (int i = 0; i < 26; i++) begin
            base_tbl[lsc[i]] = int'(letters[i]);
            shf_tbl[lsc[i]]  = int'(letters[i]) - 32;
            ltr_tbl[lsc[i]]  = 1'b1;
            pool.push_back(lsc[i]);
        end
        for (int i = 0; i < 21; i++) begin
            base_tbl[gsc[i]] = lo_tbl[i];
            shf_tbl[gsc[i]]  = hi_tbl[i];
            pool.push_back(gsc[i]);
        end
        for (int i = 0; i < 27; i++) begin
            base_tbl[spk[i]] = spc[i];
            shf_tbl[spk[i]]  = spc[i];
            pool.push_back(spk[i]);
        end
        // Modifiers and keys that must stay unmapped.
        for (int r = 0; r < 4; r++) begin
            pool.push_back('h012); pool.push_back('h059); pool.push_back('h058);
        end
        pool.push_back('h014); pool.push_back('h011); pool.push_back('h06B);
        pool.push_back('h11F); pool.push_back('h070); pool.push_back('h114);
    endtask

    task automatic model_reset();
        m_kbd = 0; m_held = -1; m_lsh = 0; m_rsh = 0; m_caps = 0; m_strobe = 0;
    endtask

    task automatic model_event(input bit mk, input int k);
        int prev, code;
        bit sh;
        prev = m_kbd;
        sh = m_lsh | m_rsh;
        if (k == 'h012) m_lsh = mk;
        else if (k == 'h059) m_rsh = mk;
        else if (k == 'h058) begin
            if (mk) m_caps = ~m_caps;
        end else if (mk) begin
            if (base_tbl[k] >= 0) begin
                if (ltr_tbl[k]) code = (sh ^ m_caps) ? shf_tbl[k] : base_tbl[k];
                else            code = sh ? shf_tbl[k] : base_tbl[k];
                m_kbd  = code;
                m_held = k;
            end
        end else if (m_held == k) begin
            m_kbd  = 0;
            m_held = -1;
        end
        m_strobe = (m_kbd != prev);
    endtask

    // Called at a falling edge; toggles bit 10, then checks after the next rising edge.
    task automatic ev(input bit mk, input bit ext, input logic [7:0] sc);
        ps2_key = {~ps2_key[10], mk, ext, sc};
        model_event(mk, int'({ext, sc}));
        @(negedge clk);
        $display("[TB] ev %s %s%02h -> kbd=%0d strobe=%0d caps=%0d",
                 mk ? "make " : "break", ext ? "E0 " : "", sc, kbd, kbd_strobe, caps);
        chk("ev_kbd", 32'(kbd), 32'(m_kbd));
        chk("ev_strobe", 32'(kbd_strobe), 32'(m_strobe));
        chk("ev_caps", 32'(caps), 32'(m_caps));
    endtask

    task automatic idle();
        @(negedge clk);
        chk("idle_kbd", 32'(kbd), 32'(m_kbd));
        chk("idle_strobe", 32'(kbd_strobe), 32'd0);
    endtask

    initial begin
        int k;
        bit mk;
        build_tables();
        model_reset();

        // Reset arming: bit 10 already high at release must not count as an event.
        reset_n = 1'b0;
        ps2_key = 11'h400;
        repeat (3) @(negedge clk);
        chk("rst_kbd", 32'(kbd), 32'd0);
        chk("rst_strobe", 32'(kbd_strobe), 32'd0);
        chk("rst_caps", 32'(caps), 32'd0);
        reset_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("arm_kbd", 32'(kbd), 32'd0);
            chk("arm_strobe", 32'(kbd_strobe), 32'd0);
        end

        // Letter and release.
        ev(1, 0, 8'h1C); chk("a_97", 32'(kbd), 32'd97); chk("a_strobe", 32'(kbd_strobe), 32'd1);
        idle();
        ev(0, 0, 8'h1C); chk("a_rel", 32'(kbd), 32'd0);

        // Shift and caps.
        ev(1, 0, 8'h12); ev(1, 0, 8'h1C); chk("shift_A", 32'(kbd), 32'd65);
        ev(0, 0, 8'h1C);
        ev(1, 0, 8'h58); ev(0, 0, 8'h58); chk("caps_on", 32'(caps), 32'd1);
        ev(0, 0, 8'h12); ev(1, 0, 8'h1C); chk("caps_A", 32'(kbd), 32'd65);
        ev(0, 0, 8'h1C);
        ev(1, 0, 8'h59); ev(1, 0, 8'h1C); chk("shcaps_a", 32'(kbd), 32'd97);
        ev(0, 0, 8'h1C);
        ev(1, 0, 8'h16); chk("shift_bang", 32'(kbd), 32'd33);
        ev(0, 0, 8'h16); ev(0, 0, 8'h59);
        ev(1, 0, 8'h58); ev(0, 0, 8'h58); chk("caps_off", 32'(caps), 32'd0);

        // Extended keys.
        ev(1, 1, 8'h6B); chk("left_130", 32'(kbd), 32'd130);
        ev(1, 1, 8'h5A); chk("kpenter_128", 32'(kbd), 32'd128);
        ev(1, 0, 8'h6B); chk("kp4_keep", 32'(kbd), 32'd128); chk("kp4_nostrobe", 32'(kbd_strobe), 32'd0);
        ev(0, 1, 8'h6B); chk("left_rel_keep", 32'(kbd), 32'd128);
        ev(0, 1, 8'h5A); chk("kpenter_rel", 32'(kbd), 32'd0);

        // Overlapping keys.
        ev(1, 0, 8'h1C); ev(1, 0, 8'h32); chk("ovl_b", 32'(kbd), 32'd98);
        ev(0, 0, 8'h1C); chk("ovl_keep_b", 32'(kbd), 32'd98);
        ev(0, 0, 8'h32); chk("ovl_rel", 32'(kbd), 32'd0);

        // Shift change mid-hold, and same-key re-press without strobe.
        ev(1, 0, 8'h1C); ev(1, 0, 8'h12); ev(0, 0, 8'h12); chk("mid_keep", 32'(kbd), 32'd97);
        ev(0, 0, 8'h1C); chk("mid_rel", 32'(kbd), 32'd0);
        ev(1, 0, 8'h1C); ev(1, 0, 8'h1C); chk("repress_nostrobe", 32'(kbd_strobe), 32'd0);
        ev(0, 0, 8'h1C);

        // Random traffic, mostly back-to-back, releases biased to the held key.
        for (int n = 0; n < 400; n++) begin
            k = pool[$urandom_range(0, pool.size() - 1)];
            mk = 1'($urandom_range(0, 1));
            if (!mk && m_held >= 0 && $urandom_range(0, 1) == 1) k = m_held;
            ev(mk, k[8], k[7:0]);
            if ($urandom_range(0, 7) == 0) idle();
        end
        ev(0, 0, 8'h12); ev(0, 0, 8'h59);

        // Reset mid-hold.
        ev(1, 0, 8'h07); chk("f12_152", 32'(kbd), 32'd152);
        #2 reset_n = 1'b0;
        #1;
        model_reset();
        chk("async_kbd", 32'(kbd), 32'd0);
        chk("async_strobe", 32'(kbd_strobe), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        chk("rearm_kbd", 32'(kbd), 32'd0);
        ev(0, 0, 8'h07); chk("stale_rel", 32'(kbd), 32'd0);
        ev(1, 0, 8'h1C); chk("post_rst_a", 32'(kbd), 32'd97);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/hack_kbd_decoder.md
# hack_kbd_decoder

Consumes the 11-bit `ps2_key` event word that `hps_io` delivers to `emu`. Turns it into the 16-bit Hack keyboard register value (KBD, memory-mapped at 0x6000) that the Nand2Tetris CPU reads. Tracks the shift and caps-lock state and the currently held key, so KBD holds the Hack code of the pressed key and returns to 0 on its release. Sits in `emu` between `hps_io` and the Nand2Tetris core, in the `clk_sys` domain.

## Interface
- No parameters.
- `clk`  in  1  system clock (`clk_sys`); same domain as `hps_io`.
- `reset_n`  in  1  asynchronous, active-low reset.
- `ps2_key`  in  11  `hps_io` event word:
  - [10] toggles once per event.
  - [9] 1 = press (make), 0 = release (break).
  - [8] E0-extended.
  - [7:0] set-2 scancode.
- `kbd`  out  16  Hack KBD value; 0 when no mapped key is held; bits [15:8] always 0.
- `kbd_strobe`  out  1  one-cycle pulse whenever `kbd` changes value.
- `caps`  out  1  current caps-lock state (for an OSD/LED indicator).

## Operation
- **Event detect.** An event is a cycle where `ps2_key[10]` differs from the stored toggle `tog_q`. `tog_q` follows `ps2_key[10]` every cycle.
- **Arming after reset.**
  - The first cycle after reset deassertion only loads `tog_q`; no event is taken, whatever value bit 10 has.
  - An `armed` flag records this and is set on that first cycle.
- **Modifier tracking.**
  - Left shift (0x12) and right shift (0x59, non-extended) each have their own held flag; shift = L | R.
  - Caps lock (0x58) toggles `caps` on press only.
  - Modifier events never change `kbd` or `held`.
- **Mapping: press event to Hack code.**
  - Letters: 'a'–'z' (97–122); 'A'–'Z' (65–90) when shift XOR caps.
  - Digits and US punctuation row: unshifted ASCII, or the US shifted glyph when shift is held. Caps does not affect these. Example: 0x16 gives '1' (49) or '!' (33).
  - Space 0x29 → 32.
  - Enter 0x5A and keypad Enter E0 5A → 128. Backspace 0x66 → 129.
  - Arrows (extended): left E0 6B → 130, up E0 75 → 131, right E0 74 → 132, down E0 72 → 133.
  - Navigation (extended): home E0 6C → 134, end E0 69 → 135, pgup E0 7D → 136, pgdn E0 7A → 137, insert E0 70 → 138, delete E0 71 → 139.
  - Esc 0x76 → 140. F1–F12 → 141–152, using set-2 codes 05 06 04 0C 03 0B 83 0A 01 09 78 07.
  - Anything else, including ctrl, alt, GUI and non-extended keypad keys, is unmapped.
- **Press event.**
  - Mapped key: `kbd` ← code; `held` ← {ext, scancode}. The last press wins, even if another key is still held.
  - Unmapped key: no change.
- **Release event.**
  - If {ext, scancode} equals `held`: `kbd` ← 0 and `held` ← cleared.
  - Otherwise: no change to `kbd`.
  - The code is fixed at press time. Changing shift between press and release does not alter `kbd`, and the release still matches `held`.
- **Strobe.** `kbd_strobe` = 1 for the single cycle after any update that changed `kbd`. Re-pressing the same key while its code is already in `kbd` gives no strobe.

## Timing
- Single-edge registered design; all state updates on the event edge.
- Event to `kbd`: 1 cycle. `kbd` and `kbd_strobe` are valid after the edge at which the toggle mismatch is seen.
- Back-to-back events on consecutive cycles are each processed. No event can be dropped, because `hps_io` toggles at most once per cycle.
- Reset values: `kbd` = 0, `kbd_strobe` = 0, `caps` = 0. Internally `held` = none, shift flags = 0, `armed` = 0, `tog_q` = 0.
- Reset asserted mid-hold clears everything immediately and asynchronously. Any later release of the formerly held key is ignored.

## Test plan
- **Reset arming.** Release reset with `ps2_key` = 0x400. Then: no strobe, `kbd` = 0 for 10 cycles.
- **Letter and release.** Press 0x1C ('a'), toggle. Then: `kbd` = 97 one cycle later, with a one-cycle strobe. Release 0x1C. Then: `kbd` = 0, strobe.
- **Shift and caps.** Hold L-shift, press 0x1C. Then: 65. Tap caps, then release shift and press 0x1C. Then: 65. Hold shift with caps on, press 0x1C. Then: 97. Shift, press 0x16. Then: 33.
- **Extended keys.** E0 6B → 130. E0 5A → 128. Non-extended 0x6B → `kbd` stays at its prior value and no strobe.
- **Overlapping keys.** Press 'a', then press 0x32 ('b'). Then: `kbd` 97 → 98. Release 'a'. Then: `kbd` stays 98. Release 'b'. Then: 0.
- **Shift change mid-hold and reset mid-hold.** Press 'a', press shift, release shift, release 'a'. Then: `kbd` 97 → 0. Assert `reset_n` low while F12 (152) is held. Then: `kbd` = 0 immediately.
